// File: rtl/mux_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_sched_pkg
// Shared constants, types and helpers for the round-robin selector scheduler.
//   NUM_REQ  : number of requesters sharing the selector datapath
//   SEL_W    : width of the datapath select code
//   DATA_W   : width of one selector output beat
//   BURST_W  : width of the beats-per-grant-minus-one configuration field
// -----------------------------------------------------------------------------
package mux_rr_sched_pkg;

  localparam int unsigned NUM_REQ = 31;
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned DATA_W  = 2;
  localparam int unsigned BURST_W = 2;

  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [BURST_W-1:0] burst_t;

  // Select code 31 has no requester behind it and is never driven.
  localparam sel_t SEL_INVALID = 5'd31;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Requester index reached by stepping 'off' places past 'ptr', wrapping
  // NUM_REQ-1 -> 0. off is at most NUM_REQ and ptr below NUM_REQ, so a single
  // conditional subtraction is enough to bring the sum back into range.
  function automatic sel_t rr_index(input sel_t ptr, input int unsigned off);
    int unsigned sum;
    sum = 32'(ptr) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return sum[SEL_W-1:0];
  endfunction

endpackage

// File: rtl/mux_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mux_rr_sched_if
// Bundles the requester bank, datapath feedback and downstream handshake of the
// scheduler.
//   req        : per-requester request level
//   cfg_burst  : beats per grant minus one, taken when a grant is issued
//   mux_data   : selector output for the current sel
//   sel        : select code to the selector datapath
//   grant      : one-hot owner of the running burst, zero when idle
//   out_valid  : downstream data valid
//   out_data   : downstream data
//   out_ready  : downstream accept
//   burst_done : one-cycle pulse after the last beat of a burst is accepted
// Modports:
//   slave  : the scheduler itself
//   master : the environment (requesters, selector, downstream sink)
// -----------------------------------------------------------------------------
interface mux_rr_sched_if;
  import mux_rr_sched_pkg::*;

  req_t   req;
  burst_t cfg_burst;
  data_t  mux_data;
  sel_t   sel;
  req_t   grant;
  logic   out_valid;
  data_t  out_data;
  logic   out_ready;
  logic   burst_done;

  modport slave (
    input  req, cfg_burst, mux_data, out_ready,
    output sel, grant, out_valid, out_data, burst_done
  );

  modport master (
    output req, cfg_burst, mux_data, out_ready,
    input  sel, grant, out_valid, out_data, burst_done
  );

endinterface

// File: rtl/mux_rr_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// mux_rr_sched_rr_pick
// Combinational round-robin priority finder. Searches req_i starting one place
// after last_ptr_i and wrapping NUM_REQ-1 -> 0, so the previous owner is
// considered last.
//   req_i      : request vector
//   last_ptr_i : index of the previous winner
//   found_o    : at least one request is set
//   winner_o   : first requesting index in search order (0 when none)
// -----------------------------------------------------------------------------
module mux_rr_sched_rr_pick
  import mux_rr_sched_pkg::*;
(
  input  req_t req_i,
  input  sel_t last_ptr_i,
  output logic found_o,
  output sel_t winner_o
);

  // Walk the offsets from farthest to nearest so that the nearest requesting
  // index is the last assignment made and therefore the one that sticks.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      if (req_i[rr_index(last_ptr_i, k)]) begin
        found_o  = 1'b1;
        winner_o = rr_index(last_ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_rr_sched
// Round-robin scheduler sharing the 31-input selector datapath between the
// requesters. A winner gets the select for cfg_burst+1 accepted beats; the
// selector output is passed downstream with a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requests, burst config, selector feedback, select/grant outputs
//           and the downstream handshake (see mux_rr_sched_if)
// -----------------------------------------------------------------------------
module mux_rr_sched
  import mux_rr_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mux_rr_sched_if.slave bus
);

  state_e state_q, state_d;
  sel_t   sel_q, sel_d;
  req_t   grant_q, grant_d;
  burst_t beat_cnt_q, beat_cnt_d;
  sel_t   last_ptr_q, last_ptr_d;
  logic   burst_done_q, burst_done_d;

  logic   pick_found;
  sel_t   pick_winner;
  logic   beat_fire;
  logic   start_burst;

  mux_rr_sched_rr_pick u_rr_pick (
    .req_i      (bus.req),
    .last_ptr_i (last_ptr_q),
    .found_o    (pick_found),
    .winner_o   (pick_winner)
  );

  // last_ptr resets to the top index so the first search after reset starts
  // at requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      grant_q      <= '0;
      beat_cnt_q   <= '0;
      last_ptr_q   <= sel_t'(NUM_REQ - 1);
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      last_ptr_q   <= last_ptr_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign beat_fire = (state_q == BUSY) && bus.out_ready;

  // Arbitration happens from IDLE whenever anything requests, and from BUSY
  // only on the accepted final beat, which gives back-to-back bursts with no
  // idle cycle. With out_ready low nothing changes, so the burst simply holds.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    last_ptr_d   = last_ptr_q;
    burst_done_d = 1'b0;
    start_burst  = 1'b0;

    case (state_q)
      IDLE: begin
        start_burst = pick_found;
      end
      BUSY: begin
        if (beat_fire) begin
          if (beat_cnt_q != '0) begin
            beat_cnt_d = beat_cnt_q - burst_t'(1);
          end else begin
            burst_done_d = 1'b1;
            if (pick_found) begin
              start_burst = 1'b1;
            end else begin
              state_d = IDLE;
              grant_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // cfg_burst is captured only here, so changes mid-burst wait for the next
    // grant. sel keeps its last value when returning to IDLE.
    if (start_burst) begin
      state_d    = BUSY;
      sel_d      = pick_winner;
      grant_d    = req_t'(1) << pick_winner;
      beat_cnt_d = bus.cfg_burst;
      last_ptr_d = pick_winner;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.grant      = grant_q;
  assign bus.out_valid  = (state_q == BUSY);
  assign bus.out_data   = (state_q == BUSY) ? bus.mux_data : '0;
  assign bus.burst_done = burst_done_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_sched
// Self-checking bench for mux_rr_sched. A behavioural model predicts owner,
// beats and burst completions; accepted beats and burst_done pulses are queued
// and matched by an independent monitor.
// -----------------------------------------------------------------------------
module tb_mux_rr_sched;
  import mux_rr_sched_pkg::*;

  localparam int CLK_HALF = 5;
  localparam int NR       = NUM_REQ;

  typedef struct {
    int cycle;
    int owner;
    int data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [DATA_W-1:0] inp [0:31];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  bit finished = 1'b0;

  beat_t beatQ[$];
  int    doneQ[$];

  // Model of the scheduler in terms of who owns the datapath and how many beats
  // remain, not how the RTL encodes it.
  int mOwner = -1;
  int mLeft  = 0;
  int mLast  = NR - 1;
  int mSel   = 0;

  mux_rr_sched_if bus ();

  mux_rr_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Selector datapath: out is simply the addressed input.
  assign bus.mux_data = inp[bus.sel];

  always #CLK_HALF clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] r, input logic [1:0] b,
                               input logic rdy);
    @(posedge clk);
    #1;
    bus.req       = r;
    bus.cfg_burst = b;
    bus.out_ready = rdy;
    foreach (inp[i]) inp[i] = DATA_W'($urandom);
  endtask

  function automatic int rrSearch(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelStart(input int w);
    mOwner = w;
    mSel   = w;
    mLast  = w;
    mLeft  = int'(bus.cfg_burst);
  endtask

  // Reference model: evaluated on the falling edge with this cycle's inputs.
  initial begin
    int w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mOwner = -1;
        mLeft  = 0;
        mLast  = NR - 1;
        mSel   = 0;
        doneQ.delete();
      end else begin
        checkOutput("out_valid", 32'(bus.out_valid), 32'(mOwner >= 0));
        checkOutput("grant", 32'(bus.grant),
                    (mOwner >= 0) ? (32'd1 << mOwner) : 32'd0);
        checkOutput("sel", 32'(bus.sel), 32'(mSel));
        if (mOwner >= 0) begin
          if (bus.out_ready) begin
            beatQ.push_back('{cyc, mOwner, int'(inp[mOwner])});
            if (mLeft == 0) begin
              doneQ.push_back(cyc + 1);
              w = rrSearch(bus.req, mLast);
              if (w >= 0) modelStart(w);
              else mOwner = -1;
            end else begin
              mLeft--;
            end
          end
        end else begin
          w = rrSearch(bus.req, mLast);
          if (w >= 0) modelStart(w);
        end
      end
    end
  end

  // Monitor: consumes expected beats and burst completions as the DUT shows them.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (bus.out_valid && bus.out_ready) begin
          if (beatQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_unexpected at cycle %0d: got sel %0d, expected no beat",
                     cyc, bus.sel);
          end else begin
            e = beatQ.pop_front();
            checkOutput("beat_cycle", 32'(cyc), 32'(e.cycle));
            checkOutput("beat_sel", 32'(bus.sel), 32'(e.owner));
            checkOutput("beat_data", 32'(bus.out_data), 32'(e.data));
          end
        end
        if (bus.burst_done) begin
          if (doneQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_unexpected at cycle %0d: got 1, expected 0", cyc);
          end else begin
            checkOutput("done_cycle", 32'(cyc), 32'(doneQ.pop_front()));
          end
        end
        while (doneQ.size() > 0 && doneQ[0] < cyc) begin
          checkOutput("done_missing", 32'd0, 32'(doneQ.pop_front()));
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 32'd0);
    checkOutput({tag, "_sel"}, 32'(bus.sel), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.burst_done), 32'd0);
  endtask

  initial begin
    #(20000 * CLK_HALF);
    if (!finished) begin
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
    end
  end

  initial begin
    logic [NR-1:0] r;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.cfg_burst = '0;
    bus.out_ready = 1'b1;
    foreach (inp[i]) inp[i] = DATA_W'($urandom);

    #2;
    checkResetOutputs("reset");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] single requester, one beat");
    applyStimulus(NR'(1) << 5, 2'd0, 1'b1);
    repeat (4) applyStimulus('0, 2'd0, 1'b1);

    $display("[TB] all requesting, two-beat bursts");
    repeat (66) applyStimulus('1, 2'd1, 1'b1);
    repeat (4) applyStimulus('0, 2'd0, 1'b1);

    $display("[TB] pointer wrap");
    applyStimulus(NR'(1) << 30, 2'd0, 1'b1);
    repeat (3) applyStimulus('0, 2'd0, 1'b1);
    repeat (2) applyStimulus((NR'(1) << 29) | NR'(1), 2'd0, 1'b1);
    repeat (4) applyStimulus('0, 2'd0, 1'b1);

    $display("[TB] backpressure during four-beat burst");
    applyStimulus(NR'(1) << 7, 2'd3, 1'b1);
    applyStimulus('0, 2'd3, 1'b1);
    repeat (5) applyStimulus('0, 2'd0, 1'b0);
    repeat (6) applyStimulus('0, 2'd0, 1'b1);

    $display("[TB] owner drops request mid-burst");
    repeat (2) applyStimulus((NR'(1) << 3) | (NR'(1) << 12), 2'd3, 1'b1);
    repeat (8) applyStimulus(NR'(1) << 3, 2'd3, 1'b1);
    repeat (6) applyStimulus('0, 2'd0, 1'b1);

    $display("[TB] asynchronous reset mid-burst");
    applyStimulus(NR'(1) << 9, 2'd3, 1'b1);
    repeat (2) applyStimulus('0, 2'd3, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus((NR'(1) << 2) | (NR'(1) << 20), 2'd0, 1'b1);
    repeat (4) applyStimulus('0, 2'd0, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = NR'(1) << $urandom_range(0, NR - 1);
        default: r = NR'($urandom & $urandom);
      endcase
      applyStimulus(r, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    repeat (10) applyStimulus('0, 2'd0, 1'b1);
    @(negedge clk);
    #2;
    checkOutput("beat_queue_empty", 32'(beatQ.size()), 32'd0);
    checkOutput("done_queue_empty", 32'(doneQ.size()), 32'd0);

    finished = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
